// File: rtl/muldiv_seq.sv
// muldiv_seq -- sequential signed multiply / divide unit for MUL and DIV.
//
// One add_32 instance is time-shared over a fixed schedule: operand
// negation (2 cycles), 32 shift-add / restoring-subtract iterations, then
// a two-cycle sign fix-up of the 64-bit result. Results land in HI/LO.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        request, sampled only while busy=0
//   op           0 = multiply, 1 = divide (captured with start)
//   a, b         two's complement operands (captured with start)
//   busy         high in every state except IDLE
//   done         one-cycle pulse; hi/lo valid from this cycle
//   hi, lo       product[63:32]/[31:0], or remainder / quotient
//   div_by_zero  set on divide by zero, cleared by the next accepted start
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// NEG_A  | A <- |A|
// NEG_B  | B <- |B|, seed hi=0, lo=|A|, counter=0
// RUN    | 32 shift-add (mul) or restoring-subtract (div) iterations
// FIX_LO | negate lo when the result sign requires it
// FIX_HI | negate hi (mul: carry from FIX_LO; div: remainder sign = sa)
// DONE   | done pulse, results valid

module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
endmodule

module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_NEG_A  = 3'd1;
    localparam logic [2:0] S_NEG_B  = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FIX_LO = 3'd4;
    localparam logic [2:0] S_FIX_HI = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]       state_q, state_d;
    logic             op_q, op_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    // Divide iteration: partial remainder after shifting in the next
    // dividend bit. hi < |B| <= 2^31 keeps this within 32 bits.
    logic [WIDTH-1:0] div_r;
    assign div_r = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

    add_32 u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Adder operand mux: one addition per cycle, selected by state.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            S_NEG_A: begin
                add_a   = ~a_q;
                add_cin = 1'b1;
            end
            S_NEG_B: begin
                add_a   = ~b_q;
                add_cin = 1'b1;
            end
            S_RUN: begin
                if (!op_q) begin
                    add_a = hi_q;
                    add_b = lo_q[0] ? b_q : '0;
                end else begin
                    // r - |B|; carry out means r >= |B|
                    add_a   = div_r;
                    add_b   = ~b_q;
                    add_cin = 1'b1;
                end
            end
            S_FIX_LO: begin
                add_a   = ~lo_q;
                add_cin = 1'b1;
            end
            S_FIX_HI: begin
                // Multiply propagates the carry out of the low-word negate.
                add_a   = ~hi_q;
                add_cin = op_q ? 1'b1 : carry_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    a_d   = a;
                    b_d   = b;
                    sa_d  = a[WIDTH-1];
                    sb_d  = b[WIDTH-1];
                    dbz_d = 1'b0;
                    if (op && (b == '0)) begin
                        hi_d    = a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_NEG_A;
                    end
                end
            end
            S_NEG_A: begin
                // -2^31 negates to itself and is read as magnitude 2^31.
                if (sa_q) begin
                    a_d = add_sum;
                end
                state_d = S_NEG_B;
            end
            S_NEG_B: begin
                if (sb_q) begin
                    b_d = add_sum;
                end
                hi_d    = '0;
                lo_d    = a_q;
                cnt_d   = 5'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!op_q) begin
                    hi_d = {add_cout, add_sum[WIDTH-1:1]};
                    lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
                end else if (add_cout) begin
                    hi_d = add_sum;
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = div_r;
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                // Iteration counter only; the datapath stays on add_32.
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX_LO;
                end
            end
            S_FIX_LO: begin
                if (sa_q ^ sb_q) begin
                    lo_d = add_sum;
                    if (!op_q) begin
                        carry_d = add_cout;
                    end
                end
                state_d = S_FIX_HI;
            end
            S_FIX_HI: begin
                if ((!op_q && (sa_q ^ sb_q)) || (op_q && sa_q)) begin
                    hi_d = add_sum;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= 5'd0;
            carry_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic (truncating division,
    // remainder takes the dividend's sign).
    task automatic model(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         output logic [31:0] hi_e, output logic [31:0] lo_e, output logic dbz_e);
        int     ai, bi;
        longint la, lb, p, q, r;
        ai = a_i;
        bi = b_i;
        la = ai;
        lb = bi;
        dbz_e = 1'b0;
        if (!op_i) begin
            p    = la * lb;
            hi_e = p[63:32];
            lo_e = p[31:0];
        end else if (b_i == 32'd0) begin
            hi_e  = a_i;
            lo_e  = 32'hFFFF_FFFF;
            dbz_e = 1'b1;
        end else begin
            q    = la / lb;
            r    = la % lb;
            hi_e = r[31:0];
            lo_e = q[31:0];
        end
    endtask

    // Issue one operation and check latency, busy, results, done pulse
    // width and result hold. repulse > 0 re-asserts start (with other
    // operands) so that it is sampled at that edge while busy.
    task automatic do_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         input int repulse);
        logic [31:0] hi_e, lo_e;
        logic        dbz_e;
        int          lat;
        bit          seen;
        bit          busy_ok;
        model(op_i, a_i, b_i, hi_e, lo_e, dbz_e);
        @(negedge clk);
        start = 1'b1;
        op    = op_i;
        a     = a_i;
        b     = b_i;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (repulse > 0 && lat == repulse - 1) begin
                start = 1'b1;
                op    = ~op_i;
                a     = 32'h0BAD_F00D;
                b     = 32'h0000_0003;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(lat + 1), (dbz_e ? 64'd1 : 64'd37));
        check("busy_during", 64'(busy_ok), 64'd1);
        check("hi", 64'(hi), 64'(hi_e));
        check("lo", 64'(lo), 64'(lo_e));
        check("div_by_zero", 64'(div_by_zero), 64'(dbz_e));
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold", {hi, lo}, {hi_e, lo_e});
        check("hold_dbz", 64'(div_by_zero), 64'(dbz_e));
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h8000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = $urandom_range(0, 20);
            3: v = -$urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        bit seen;
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;

        do_op(1'b0, 32'd7, 32'd6, 0);
        do_op(1'b0, 32'hFFFF_FFFD, 32'd5, 0);
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        do_op(1'b1, 32'd100, 32'd7, 0);
        do_op(1'b1, -32'd100, 32'd7, 0);
        do_op(1'b1, 32'd100, -32'd7, 0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(1'b1, 32'h1234, 32'd0, 0);
        do_op(1'b0, 32'd2, 32'd3, 0);
        do_op(1'b0, 32'd11, 32'd13, 5);

        // rst together with start at edge 10 of a running operation
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd1234;
        b     = 32'd5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_dbz", 64'(div_by_zero), 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 45; k++) begin
            if (done || busy) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        do_op(1'b0, 32'd9, 32'd9, 0);

        for (int i = 0; i < 40; i++) begin
            logic        o;
            logic [31:0] x, y;
            o = 1'($urandom_range(0, 1));
            x = pick();
            y = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
            do_op(o, x, y, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
